// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
// No logic; imported by md_arith and md_unit.
// Codes 3'd6 and 3'd7 are reserved and decode as no-ops.
package md_pkg;

   // Operation codes carried on md_op_i
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   // Controller states: idle, multiply in flight, divide in flight
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational product / quotient / remainder for MULT, MULTU, DIV, DIVU.
// Latency: zero cycles, purely combinational; md_unit registers the result at acceptance.
// No backpressure; wr_o=0 tells the caller that HI/LO must be left untouched (b=0 or non-arith op).
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             wr_o
);

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [2*WIDTH-1:0]      prod_s;
   logic [2*WIDTH-1:0]      prod_u;
   logic                    b_zero;
   logic                    div_ovf;
   logic [WIDTH-1:0]        b_udiv;
   logic signed [WIDTH-1:0] b_sdiv;
   logic signed [WIDTH-1:0] quo_s;
   logic signed [WIDTH-1:0] rem_s;
   logic [WIDTH-1:0]        quo_u;
   logic [WIDTH-1:0]        rem_u;

   // Full-width products; operands extended explicitly so signedness is unambiguous
   assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
   assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

   assign b_zero  = (b_i == '0);
   assign div_ovf = (a_i == MOST_NEG) && (b_i == ALL_ONES);

   // A zero divisor is replaced by 1 so the dividers never see it (the result is
   // discarded anyway). For MOST_NEG / -1 the divisor is steered to 1 as well,
   // which yields exactly the architectural answer: quotient MOST_NEG, remainder 0.
   assign b_udiv = b_zero ? ONE : b_i;
   assign b_sdiv = (b_zero || div_ovf) ? $signed(ONE) : $signed(b_i);

   // SV signed division truncates toward zero and % takes the dividend's sign
   assign quo_s = $signed(a_i) / b_sdiv;
   assign rem_s = $signed(a_i) % b_sdiv;
   assign quo_u = a_i / b_udiv;
   assign rem_u = a_i % b_udiv;

   // Select the result pair for the requested operation
   always_comb begin
      hi_o = '0;
      lo_o = '0;
      wr_o = 1'b0;
      case (op_i)
         MD_MULT: begin
            {hi_o, lo_o} = prod_s;
            wr_o         = 1'b1;
         end
         MD_MULTU: begin
            {hi_o, lo_o} = prod_u;
            wr_o         = 1'b1;
         end
         MD_DIV: begin
            hi_o = rem_s;
            lo_o = quo_s;
            wr_o = !b_zero;
         end
         MD_DIVU: begin
            hi_o = rem_u;
            lo_o = quo_u;
            wr_o = !b_zero;
         end
         default: begin
            hi_o = '0;
            lo_o = '0;
            wr_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Latency: MTHI/MTLO visible next cycle; MULT* busy MULT_CYCLES, DIV* busy DIV_CYCLES, then HI/LO update with a done pulse.
// Backpressure: start is ignored while busy_o=1 (no queueing); the core must stall on busy_o.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             start_i,
   input  logic [2:0]       md_op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW    = $clog2(MAX_N + 1);

   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_1  = CW'(1);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic             res_wr_q, res_wr_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic             idle;
   logic             acc_mul;
   logic             acc_div;
   logic             acc_mthi;
   logic             acc_mtlo;
   logic             last;

   logic [WIDTH-1:0] ar_hi;
   logic [WIDTH-1:0] ar_lo;
   logic             ar_wr;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op_i (md_op_i),
      .a_i  (a_i),
      .b_i  (b_i),
      .hi_o (ar_hi),
      .lo_o (ar_lo),
      .wr_o (ar_wr)
   );

   // Controller state register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Controller next state: launch on an accepted long op, return when the count expires
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (acc_mul) begin
               state_d = MUL;
            end else if (acc_div) begin
               state_d = DIV;
            end
         end
         MUL, DIV: begin
            if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller outputs: op decode gated by idle, and end-of-operation strobe
   always_comb begin
      idle     = (state_q == IDLE);
      acc_mul  = 1'b0;
      acc_div  = 1'b0;
      acc_mthi = 1'b0;
      acc_mtlo = 1'b0;
      if (start_i && idle) begin
         case (md_op_i)
            MD_MULT, MD_MULTU: acc_mul  = 1'b1;
            MD_DIV,  MD_DIVU:  acc_div  = 1'b1;
            MD_MTHI:           acc_mthi = 1'b1;
            MD_MTLO:           acc_mtlo = 1'b1;
            default:           ;
         endcase
      end
      last = !idle && (cnt_q == CNT_1);
   end

   // Datapath next state: result capture, cycle counter, HI/LO write-back, done pulse
   always_comb begin
      cnt_d    = cnt_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_wr_d = res_wr_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = last;

      if (acc_mul || acc_div) begin
         cnt_d    = acc_mul ? MULT_N : DIV_N;
         res_hi_d = ar_hi;
         res_lo_d = ar_lo;
         res_wr_d = ar_wr;
      end else if (!idle) begin
         cnt_d = cnt_q - CNT_1;
      end

      // MTHI/MTLO only happen while idle and write-back only while busy, so these never collide
      if (acc_mthi) begin
         hi_d = a_i;
      end
      if (acc_mtlo) begin
         lo_d = a_i;
      end
      if (last && res_wr_q) begin
         hi_d = res_hi_q;
         lo_d = res_lo_q;
      end
   end

   // Datapath registers; reset discards any in-flight result
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q    <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         res_wr_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         res_wr_q <= res_wr_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy_o = !idle;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default parameters.
// Each long op is followed cycle by cycle: busy window, HI/LO hold, done pulse, result.
// Expected HI/LO are tracked in bench-side model registers m_hi/m_lo.
module tb_md_unit;
   import md_pkg::*;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b0;
   logic         start   = 1'b0;
   logic [2:0]   md_op   = 3'd0;
   logic [W-1:0] a       = '0;
   logic [W-1:0] b       = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           total  = 0;
   int           passed = 0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;

   md_unit #(
      .WIDTH       (W),
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .start_i  (start),
      .md_op_i  (md_op),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .hi_o     (hi),
      .lo_o     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single edge; check acceptance state right after it
   task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic exp_busy, input string tag);
      md_op = op;
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
      chk({tag, "_done_low"}, 64'(done), 64'd0);
   endtask

   // Follow a long op from E0+1 through E_N; optionally poke an MTLO while busy
   task automatic run_long(input int n, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input bit poke, input string tag);
      bit ok;
      ok = 1'b1;
      for (int i = 1; i < n; i++) begin
         tick();
         if (!(busy === 1'b1 && done === 1'b0 && hi === m_hi && lo === m_lo)) ok = 1'b0;
         if (poke && i == 2) begin
            md_op = MD_MTLO;
            a     = 32'h0000_0055;
            start = 1'b1;
         end
         if (poke && i == 3) start = 1'b0;
      end
      chk({tag, "_busy_window"}, 64'(ok), 64'd1);
      tick();
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      bit quiet;

      // Reset state
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      reset_n = 1'b1;
      tick();

      // MULT -2 * 3 = -6
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult");
      run_long(MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult");

      // MULTU issued at E_N+1 (back-to-back): 0xFFFFFFFF * 2
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu_b2b");
      run_long(MC, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu");

      // DIV -7 / 2 with an MTLO attempted while busy (must be ignored)
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
      run_long(DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, "div");

      // DIVU 7 / 2
      issue(MD_DIVU, 32'd7, 32'd2, 1'b1, "divu");
      run_long(DC, 32'd1, 32'd3, 1'b0, "divu");

      // MTHI / MTLO preload
      issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, "mthi");
      chk("mthi_hi", 64'(hi), 64'h1234_5678);
      m_hi = 32'h1234_5678;
      issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0, "mtlo");
      chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
      chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
      m_lo = 32'h9ABC_DEF0;

      // DIV by zero: full latency, done pulses, HI/LO unchanged
      issue(MD_DIV, 32'd100, 32'd0, 1'b1, "div0");
      run_long(DC, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "div0");

      // Signed overflow: most-negative / -1
      tick();
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divovf");
      run_long(DC, 32'h0000_0000, 32'h8000_0000, 1'b0, "divovf");

      // Reserved op codes: no state change
      issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, "rsv6");
      chk("rsv6_hi", 64'(hi), 64'(m_hi));
      chk("rsv6_lo", 64'(lo), 64'(m_lo));
      issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, "rsv7");
      chk("rsv7_lo", 64'(lo), 64'(m_lo));

      // DIV 7 / -2: quotient -3, remainder +1 (sign of dividend)
      issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, "divneg");
      run_long(DC, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "divneg");

      // Asynchronous reset in the middle of a DIV
      tick();
      issue(MD_DIV, 32'd1000, 32'd3, 1'b1, "divrst");
      tick();
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      m_hi = '0;
      m_lo = '0;
      tick();
      reset_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < DC + 2; i++) begin
         tick();
         if (!(done === 1'b0 && busy === 1'b0 && hi === '0 && lo === '0)) quiet = 1'b0;
      end
      chk("arst_no_done", 64'(quiet), 64'd1);

      // Normal MULT after reset: 7 * -3 = -21
      issue(MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, "mult_after_rst");
      run_long(MC, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_after_rst");
      tick();
      chk("final_done_low", 64'(done), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, for the next-generation MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Asserts busy so the stall logic can hold dependent MFHI/MFLO and md instructions.
- Sits beside the ALU in the execute stage; results are read directly from the hi/lo outputs.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- MULT_CYCLES, 5: busy cycles for MULT/MULTU; must be at least 1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request valid this cycle.
- md_op  input  3  operation code (see package).
- a  input  WIDTH  operand rs (dividend, multiplicand, or MTHI/MTLO data).
- b  input  WIDTH  operand rt (divisor, multiplier).
- busy  output  1  long operation in flight.
- done  output  1  one-cycle pulse when HI/LO are written by a long operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0, counter=0.
  - Any in-flight operation is discarded.
- Acceptance:
  - start is sampled on a rising edge only when busy=0.
  - start while busy=1 is ignored entirely; no queueing. The core must stall instead.
- MTHI / MTLO:
  - When accepted, hi (resp. lo) takes a at that edge.
  - busy stays 0 and done stays 0.
- Long operations (MULT, MULTU, DIV, DIVU): on acceptance at edge E0:
  - a and b are latched.
  - The result is computed into internal result registers.
  - counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 from E0.
- Counting:
  - At each following edge, counter decrements.
  - At edge E_N (counter 1 -> 0), hi/lo take the latched result, busy falls to 0, and done=1.
  - done returns to 0 at E_N+1.
  - busy is therefore high for exactly N cycles.
  - hi/lo keep their old values while busy=1.
- Back-to-back: start may be accepted again in the cycle after busy falls (sampled at E_N+1).
- States:
  - IDLE -> MUL or DIV on accepted long op.
  - MUL/DIV -> IDLE when counter reaches 0.
  - done is a registered pulse.
- Arithmetic:
  - MULT: signed WIDTHxWIDTH -> 2*WIDTH product; hi = upper half, lo = lower half.
  - MULTU: as MULT, unsigned.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned; lo = quotient, hi = remainder.
- Boundary conditions:
  - Divide by zero (b=0, DIV or DIVU): runs the full DIV_CYCLES; hi/lo are unchanged at E_N; done still pulses.
  - Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
  - Unknown md_op with start=1: treated as no-op; no state change.
  - Reset mid-operation: busy drops immediately (asynchronously); no done pulse; hi=lo=0.

Decomposition:
- Shared package `md_pkg`:
  - md_op encodings: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5; 3'd6 and 3'd7 reserved.
  - State encodings: IDLE, MUL, DIV.
- One natural sub-module, `md_arith`:
  - Purely combinational signed/unsigned product, quotient and remainder, including the zero and overflow rules.
  - Its output is registered by md_unit at acceptance.
- The Controller gains the md_op decode and the start signal.
- The datapath gains the busy-driven stall.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, defaults -> busy high for 5 cycles; at E5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses one cycle.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- Preload via MTHI 0x12345678 and MTLO 0x9ABCDEF0 (each visible the next cycle, busy=0); then DIV with b=0 -> busy 10 cycles, done pulses, hi/lo still 0x12345678/0x9ABCDEF0.
- Boundary cases:
  - DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - MTLO 0x55 issued while busy -> ignored; lo shows only the division result.
  - start at E_N+1 -> accepted.
- Start DIV, assert reset=0 asynchronously at cycle 4 -> busy=0, hi=lo=0 immediately, no done pulse; after release a new MULT completes normally.
